fu_sequencer: RTL and testbench

FU_SEQUENCER -- requirements
Module: fu_sequencer

---
 rtl/fu_sequencer_pkg.sv | 35 +++
 rtl/fu_sequencer_if.sv | 56 +++++
 rtl/fu_result_fifo.sv | 72 +++++++
 rtl/fu_sequencer.sv | 123 ++++++++++++
 tb/tb_fu_sequencer.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fu_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fu_sequencer_pkg
// Brief   : Shared widths, default parameters and opcode names for the
//           functional-unit sequencer, its functional unit and its bench.
// Revision: 1.0 - initial release
// ============================================================================
package fu_sequencer_pkg;

  localparam int c_DATA_W         = 32;
  localparam int c_INST_W         = 5;
  localparam int c_FLAGS_W        = 4;
  localparam int c_DEF_LATENCY    = 1;
  localparam int c_DEF_FIFO_DEPTH = 4;
  localparam int c_DEF_TAG_W      = 4;

  // Base opcodes of the functional unit; codes above 7 are variants.
  typedef enum logic [c_INST_W-1:0] {
    OP_ADD = 5'd0,
    OP_SUB = 5'd1,
    OP_AND = 5'd2,
    OP_OR  = 5'd3,
    OP_XOR = 5'd4,
    OP_MAC = 5'd5,
    OP_SHL = 5'd6,
    OP_SHR = 5'd7
  } fu_op_e;

  // Counter width that can hold 0..depth inclusive (full and empty distinct).
  function automatic int fu_cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fu_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module  : fu_sequencer_if
// Brief   : Request, response and functional-unit signal bundle. The slave
//           modport is the sequencer; the master modport is its environment
//           (request producer, response consumer and the functional unit).
// Revision: 1.0 - initial release
// ============================================================================
interface fu_sequencer_if
  import fu_sequencer_pkg::*;
#(
  parameter int TAG_W = c_DEF_TAG_W
) ();

  // request channel
  logic                 REQ_VALID;
  logic                 REQ_READY;
  logic [c_DATA_W-1:0]  REQ_A;
  logic [c_DATA_W-1:0]  REQ_B;
  logic [c_DATA_W-1:0]  REQ_C;
  logic [c_INST_W-1:0]  REQ_INST;
  logic                 REQ_CI;
  logic [TAG_W-1:0]     REQ_TAG;

  // functional unit side
  logic [c_DATA_W-1:0]  FU_A;
  logic [c_DATA_W-1:0]  FU_B;
  logic [c_DATA_W-1:0]  FU_C;
  logic [c_INST_W-1:0]  FU_INST;
  logic                 FU_CI;
  logic [c_DATA_W-1:0]  FU_Z;
  logic [c_FLAGS_W-1:0] FU_FLAGS;

  // response channel
  logic                 RSP_VALID;
  logic                 RSP_READY;
  logic [c_DATA_W-1:0]  RSP_Z;
  logic [c_FLAGS_W-1:0] RSP_FLAGS;
  logic [TAG_W-1:0]     RSP_TAG;

  modport master (
    output REQ_VALID, REQ_A, REQ_B, REQ_C, REQ_INST, REQ_CI, REQ_TAG,
    output RSP_READY, FU_Z, FU_FLAGS,
    input  REQ_READY, RSP_VALID, RSP_Z, RSP_FLAGS, RSP_TAG,
    input  FU_A, FU_B, FU_C, FU_INST, FU_CI
  );

  modport slave (
    input  REQ_VALID, REQ_A, REQ_B, REQ_C, REQ_INST, REQ_CI, REQ_TAG,
    input  RSP_READY, FU_Z, FU_FLAGS,
    output REQ_READY, RSP_VALID, RSP_Z, RSP_FLAGS, RSP_TAG,
    output FU_A, FU_B, FU_C, FU_INST, FU_CI
  );

endinterface
`default_nettype wire

// File: rtl/fu_result_fifo.sv
`default_nettype none
// ============================================================================
// Module  : fu_result_fifo
// Brief   : Synchronous result FIFO with occupancy count, synchronous flush
//           and asynchronous active-low reset. Head is zero while empty.
// Revision: 1.0 - initial release
// ============================================================================
module fu_result_fifo
  import fu_sequencer_pkg::*;
#(
  parameter int DEPTH = c_DEF_FIFO_DEPTH,
  parameter int WIDTH = 40
) (
  input  wire logic                       clk,
  input  wire logic                       rst_n,
  input  wire logic                       i_flush,
  input  wire logic                       i_push,
  input  wire logic [WIDTH-1:0]           i_data,
  input  wire logic                       i_pop,
  output logic      [WIDTH-1:0]           o_data,
  output logic                            o_valid,
  output logic      [fu_cnt_w(DEPTH)-1:0] o_count
);

  localparam int                 c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int                 c_CNT_W = fu_cnt_w(DEPTH);
  localparam logic [c_PTR_W-1:0] c_LAST  = c_PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [c_PTR_W-1:0] r_wptr;
  logic [c_PTR_W-1:0] r_rptr;
  logic [c_CNT_W-1:0] r_count;
  logic               w_wr;
  logic               w_rd;

  function automatic logic [c_PTR_W-1:0] next_ptr(input logic [c_PTR_W-1:0] p);
    return (p == c_LAST) ? '0 : p + 1'b1;
  endfunction

  // A flush discards whatever would have been written or read on that edge.
  assign w_wr    = i_push & ~i_flush;
  assign w_rd    = i_pop & o_valid & ~i_flush;
  assign o_valid = (r_count != '0);
  assign o_data  = o_valid ? r_mem[r_rptr] : '0;
  assign o_count = r_count;

  // Storage array: written at the tail, no reset needed.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wptr] <= i_data;
    end
  end

  // Pointers and occupancy; simultaneous push and pop leave the count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) r_wptr <= next_ptr(r_wptr);
      if (w_rd) r_rptr <= next_ptr(r_rptr);
      r_count <= r_count + c_CNT_W'(w_wr) - c_CNT_W'(w_rd);
    end
  end

endmodule
`default_nettype wire

// File: rtl/fu_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : fu_sequencer
// Brief   : Issues requests to a fixed-latency functional unit, tracks them
//           with a valid/tag pipeline and buffers results in order with
//           credit-based flow control so the result FIFO never overflows.
// Revision: 1.0 - initial release
// ============================================================================
module fu_sequencer
  import fu_sequencer_pkg::*;
#(
  parameter int LATENCY    = c_DEF_LATENCY,
  parameter int FIFO_DEPTH = c_DEF_FIFO_DEPTH,
  parameter int TAG_W      = c_DEF_TAG_W
) (
  input  wire logic     CLOCK,
  input  wire logic     RESET_N,
  input  wire logic     FLUSH,
  fu_sequencer_if.slave bus
);

  localparam int                 c_CNT_W   = fu_cnt_w(FIFO_DEPTH);
  localparam int                 c_ENTRY_W = TAG_W + c_FLAGS_W + c_DATA_W;
  localparam logic [c_CNT_W:0]   c_DEPTH_V = FIFO_DEPTH[c_CNT_W:0];

  logic [c_DATA_W-1:0]  r_fu_a;
  logic [c_DATA_W-1:0]  r_fu_b;
  logic [c_DATA_W-1:0]  r_fu_c;
  logic [c_INST_W-1:0]  r_fu_inst;
  logic                 r_fu_ci;
  logic [LATENCY:0]     r_pv;
  logic [TAG_W-1:0]     r_ptag [LATENCY+1];
  logic [c_CNT_W-1:0]   r_inflight;

  logic [c_CNT_W-1:0]   w_fifo_count;
  logic [c_CNT_W:0]     w_credit_used;
  logic                 w_ready;
  logic                 w_accept;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_rsp_valid;
  logic [c_ENTRY_W-1:0] w_push_data;
  logic [c_ENTRY_W-1:0] w_head;

  // Credits come only from registered counts, so a pop frees a slot one
  // cycle later and there is no path from REQ_VALID or RSP_READY to REQ_READY.
  assign w_credit_used = {1'b0, w_fifo_count} + {1'b0, r_inflight};
  assign w_ready       = RESET_N & ~FLUSH & (w_credit_used < c_DEPTH_V);
  assign w_accept      = bus.REQ_VALID & w_ready;
  assign w_push        = r_pv[LATENCY];
  assign w_pop         = w_rsp_valid & bus.RSP_READY;
  assign w_push_data   = {r_ptag[LATENCY], bus.FU_FLAGS, bus.FU_Z};

  // Operand registers feeding the functional unit; hold when idle.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_fu_a    <= '0;
      r_fu_b    <= '0;
      r_fu_c    <= '0;
      r_fu_inst <= '0;
      r_fu_ci   <= 1'b0;
    end else if (w_accept) begin
      r_fu_a    <= bus.REQ_A;
      r_fu_b    <= bus.REQ_B;
      r_fu_c    <= bus.REQ_C;
      r_fu_inst <= bus.REQ_INST;
      r_fu_ci   <= bus.REQ_CI;
    end
  end

  // Valid/tag tracking pipeline; the last stage marks when FU_Z is ready.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_pv <= '0;
      for (int i = 0; i <= LATENCY; i++) r_ptag[i] <= '0;
    end else if (FLUSH) begin
      r_pv <= '0;
    end else begin
      r_pv      <= {r_pv[LATENCY-1:0], w_accept};
      r_ptag[0] <= bus.REQ_TAG;
      for (int i = 1; i <= LATENCY; i++) r_ptag[i] <= r_ptag[i-1];
    end
  end

  // Number of accepted requests not yet written into the FIFO.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_inflight <= '0;
    end else if (FLUSH) begin
      r_inflight <= '0;
    end else begin
      r_inflight <= r_inflight + c_CNT_W'(w_accept) - c_CNT_W'(w_push);
    end
  end

  fu_result_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (c_ENTRY_W)
  ) u_fifo (
    .clk     (CLOCK),
    .rst_n   (RESET_N),
    .i_flush (FLUSH),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_valid (w_rsp_valid),
    .o_count (w_fifo_count)
  );

  assign bus.REQ_READY = w_ready;
  assign bus.RSP_VALID = w_rsp_valid;
  assign bus.RSP_Z     = w_head[c_DATA_W-1:0];
  assign bus.RSP_FLAGS = w_head[c_DATA_W +: c_FLAGS_W];
  assign bus.RSP_TAG   = w_head[c_DATA_W+c_FLAGS_W +: TAG_W];
  assign bus.FU_A      = r_fu_a;
  assign bus.FU_B      = r_fu_b;
  assign bus.FU_C      = r_fu_c;
  assign bus.FU_INST   = r_fu_inst;
  assign bus.FU_CI     = r_fu_ci;

endmodule
`default_nettype wire

// File: tb/tb_fu_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_fu_sequencer
// Brief   : Directed self-checking bench for fu_sequencer with a behavioural
//           functional unit and an in-order expected-result queue.
// Revision: 1.0 - initial release
// ============================================================================
module tb_fu_sequencer;
  import fu_sequencer_pkg::*;

  localparam int LAT = 1;

  typedef struct packed {
    logic [3:0]  tag;
    logic [35:0] res;
  } exp_t;

  logic CLOCK;
  logic RESET_N;
  logic FLUSH;

  fu_sequencer_if #(.TAG_W(4)) bus ();

  fu_sequencer #(
    .LATENCY    (LAT),
    .FIFO_DEPTH (4),
    .TAG_W      (4)
  ) dut (
    .CLOCK   (CLOCK),
    .RESET_N (RESET_N),
    .FLUSH   (FLUSH),
    .bus     (bus)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_rsp    = 0;
  int   n_acc    = 0;
  logic [3:0] last_tag = '0;
  exp_t exp_q[$];

  // Reference arithmetic for the functional unit: {N, Z, C, CI, result}.
  function automatic logic [35:0] ref_alu(input logic [4:0] inst, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] c,
                                          input logic ci);
    logic [32:0] w;
    logic [31:0] z;
    logic        cy;
    w  = '0;
    z  = '0;
    cy = 1'b0;
    case (inst[2:0])
      3'd0: begin w = {1'b0, a} + {1'b0, b} + {32'b0, ci}; z = w[31:0]; cy = w[32]; end
      3'd1: begin w = {1'b0, a} - {1'b0, b}; z = w[31:0]; cy = w[32]; end
      3'd2: z = a & b;
      3'd3: z = a | b;
      3'd4: z = a ^ b ^ c;
      3'd5: z = a * b + c;
      3'd6: z = a << b[4:0];
      default: z = a >> b[4:0];
    endcase
    if (inst[4:3] != 2'b00) z = z ^ {27'b0, inst};
    return {z[31], (z == 32'd0), cy, ci, z};
  endfunction

  // Behavioural functional unit: LAT register stages after the FU_* operands.
  logic [35:0] fu_pipe [LAT];
  always @(posedge CLOCK) begin
    fu_pipe[0] <= ref_alu(bus.FU_INST, bus.FU_A, bus.FU_B, bus.FU_C, bus.FU_CI);
    for (int i = 1; i < LAT; i++) fu_pipe[i] <= fu_pipe[i-1];
  end
  assign bus.FU_Z     = fu_pipe[LAT-1][31:0];
  assign bus.FU_FLAGS = fu_pipe[LAT-1][35:32];

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_req(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                           input logic [4:0] inst, input logic ci, input logic [3:0] tag);
    bus.REQ_VALID = 1'b1;
    bus.REQ_A     = a;
    bus.REQ_B     = b;
    bus.REQ_C     = c;
    bus.REQ_INST  = inst;
    bus.REQ_CI    = ci;
    bus.REQ_TAG   = tag;
  endtask

  // One clock: record handshakes seen before the edge, then step past it.
  task automatic tick();
    logic pop;
    logic acc;
    logic fl;
    exp_t e;
    #3;
    pop = bus.RSP_VALID && bus.RSP_READY;
    acc = bus.REQ_VALID && bus.REQ_READY;
    fl  = FLUSH;
    if (pop) begin
      n_rsp++;
      last_tag = bus.RSP_TAG;
      if (exp_q.size() == 0) begin
        check_val("rsp_unexpected", 64'(bus.RSP_VALID), 64'd0);
      end else begin
        e = exp_q.pop_front();
        check_val("rsp_tag",   64'(bus.RSP_TAG),   64'(e.tag));
        check_val("rsp_z",     64'(bus.RSP_Z),     64'(e.res[31:0]));
        check_val("rsp_flags", 64'(bus.RSP_FLAGS), 64'(e.res[35:32]));
      end
    end
    if (acc) begin
      n_acc++;
      e.tag = bus.REQ_TAG;
      e.res = ref_alu(bus.REQ_INST, bus.REQ_A, bus.REQ_B, bus.REQ_C, bus.REQ_CI);
      exp_q.push_back(e);
    end
    if (fl) exp_q.delete();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic drain(input string tag, input int max_cycles);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < max_cycles) begin
      tick();
      k++;
    end
    check_val({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_req_ready"}, 64'(bus.REQ_READY), 64'd0);
    check_val({tag, "_rsp"}, 64'({bus.RSP_VALID, bus.RSP_TAG, bus.RSP_FLAGS, bus.RSP_Z}), 64'd0);
    check_val({tag, "_fu_ab"}, {bus.FU_A, bus.FU_B}, 64'd0);
    check_val({tag, "_fu_c"}, 64'({bus.FU_C, bus.FU_INST, bus.FU_CI}), 64'd0);
  endtask

  initial begin
    int rsp0;
    int acc0;
    int k;
    int ready_low;

    RESET_N       = 1'b0;
    FLUSH         = 1'b0;
    bus.REQ_VALID = 1'b0;
    bus.REQ_A     = '0;
    bus.REQ_B     = '0;
    bus.REQ_C     = '0;
    bus.REQ_INST  = '0;
    bus.REQ_CI    = 1'b0;
    bus.REQ_TAG   = '0;
    bus.RSP_READY = 1'b0;

    // ---- reset state ----
    repeat (2) tick();
    check_reset_outputs("rst");
    RESET_N = 1'b1;
    #1;
    check_val("ready_after_rst", 64'(bus.REQ_READY), 64'd1);

    // ---- single op: 5 + 3 ----
    bus.RSP_READY = 1'b1;
    drive_req(32'd5, 32'd3, 32'd0, OP_ADD, 1'b0, 4'd1);
    tick();
    bus.REQ_VALID = 1'b0;
    check_val("single_fu_a", 64'(bus.FU_A), 64'd5);
    check_val("single_fu_b", 64'(bus.FU_B), 64'd3);
    check_val("single_rsp_t0", 64'(bus.RSP_VALID), 64'd0);
    tick();
    check_val("single_rsp_t1", 64'(bus.RSP_VALID), 64'd0);
    tick();
    check_val("single_rsp_valid", 64'(bus.RSP_VALID), 64'd1);
    check_val("single_rsp_z", 64'(bus.RSP_Z), 64'd8);
    check_val("single_rsp_tag", 64'(bus.RSP_TAG), 64'd1);
    tick();
    check_val("single_idle", 64'(bus.RSP_VALID), 64'd0);

    // ---- back-to-back: 32 requests, every opcode ----
    rsp0      = n_rsp;
    ready_low = 0;
    for (int i = 0; i < 32; i++) begin
      drive_req($urandom, $urandom, $urandom, 5'(i), 1'($urandom_range(0, 1)), 4'(i));
      #1;
      if (!bus.REQ_READY) ready_low++;
      tick();
    end
    bus.REQ_VALID = 1'b0;
    drain("b2b", 20);
    check_val("b2b_ready_low", 64'(ready_low), 64'd0);
    check_val("b2b_rsp_count", 64'(n_rsp - rsp0), 64'd32);

    // ---- backpressure: consumer stalled ----
    bus.RSP_READY = 1'b0;
    acc0 = n_acc;
    for (int i = 0; i < 8; i++) begin
      drive_req($urandom, $urandom, 32'd0, OP_XOR, 1'b0, 4'(8 + i));
      tick();
    end
    bus.REQ_VALID = 1'b0;
    check_val("bp_accepts", 64'(n_acc - acc0), 64'd4);
    check_val("bp_ready_low", 64'(bus.REQ_READY), 64'd0);
    check_val("bp_rsp_valid", 64'(bus.RSP_VALID), 64'd1);
    bus.RSP_READY = 1'b1;
    tick();
    bus.RSP_READY = 1'b0;
    check_val("bp_ready_back", 64'(bus.REQ_READY), 64'd1);

    // ---- FIFO at 3: push and pop on the same edge ----
    drive_req(32'd100, 32'd7, 32'd0, OP_SUB, 1'b0, 4'd12);
    tick();
    bus.REQ_VALID = 1'b0;
    check_val("full_ready_low", 64'(bus.REQ_READY), 64'd0);
    tick();
    bus.RSP_READY = 1'b1;
    tick();
    bus.RSP_READY = 1'b0;
    check_val("full_head_adv", 64'(bus.RSP_TAG), 64'd10);
    check_val("full_ready", 64'(bus.REQ_READY), 64'd1);
    check_val("full_rsp_valid", 64'(bus.RSP_VALID), 64'd1);
    rsp0 = n_rsp;
    bus.RSP_READY = 1'b1;
    drain("full", 10);
    tick();
    check_val("full_drain_count", 64'(n_rsp - rsp0), 64'd3);
    check_val("full_empty", 64'(bus.RSP_VALID), 64'd0);

    // ---- flush with 2 buffered + 1 in flight ----
    bus.RSP_READY = 1'b0;
    drive_req(32'd1, 32'd2, 32'd0, OP_ADD, 1'b0, 4'd1);
    tick();
    drive_req(32'd3, 32'd4, 32'd0, OP_ADD, 1'b0, 4'd2);
    tick();
    drive_req(32'd5, 32'd6, 32'd0, OP_ADD, 1'b0, 4'd3);
    tick();
    bus.REQ_VALID = 1'b0;
    tick();
    check_val("flush_pre_valid", 64'(bus.RSP_VALID), 64'd1);
    FLUSH = 1'b1;
    #1;
    check_val("flush_ready_low", 64'(bus.REQ_READY), 64'd0);
    tick();
    FLUSH = 1'b0;
    #1;
    check_val("flush_rsp_valid", 64'(bus.RSP_VALID), 64'd0);
    check_val("flush_ready", 64'(bus.REQ_READY), 64'd1);
    rsp0 = n_rsp;
    bus.RSP_READY = 1'b1;
    repeat (6) tick();
    check_val("flush_no_stale", 64'(n_rsp - rsp0), 64'd0);

    // ---- reset mid-stream with 4 outstanding ----
    bus.RSP_READY = 1'b0;
    acc0 = n_acc;
    for (int i = 0; i < 4; i++) begin
      drive_req($urandom, $urandom, $urandom, OP_MAC, 1'b0, 4'(4 + i));
      tick();
    end
    bus.REQ_VALID = 1'b0;
    check_val("rstm_accepts", 64'(n_acc - acc0), 64'd4);
    RESET_N = 1'b0;
    #1;
    check_reset_outputs("rstm_early");
    exp_q.delete();
    repeat (3) tick();
    check_reset_outputs("rstm_late");
    RESET_N = 1'b1;
    #1;
    check_val("rstm_ready", 64'(bus.REQ_READY), 64'd1);
    bus.RSP_READY = 1'b1;
    rsp0 = n_rsp;
    drive_req(32'd20, 32'd22, 32'd0, OP_ADD, 1'b1, 4'd9);
    tick();
    bus.REQ_VALID = 1'b0;
    k = 0;
    while (n_rsp == rsp0 && k < 10) begin
      tick();
      k++;
    end
    repeat (4) tick();
    check_val("rstm_one_rsp", 64'(n_rsp - rsp0), 64'd1);
    check_val("rstm_tag", 64'(last_tag), 64'd9);
    check_val("rstm_idle", 64'(bus.RSP_VALID), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
